// File: rtl/qspi_flash_burst_reader.sv
// qspi_flash_burst_reader
//   SPI / Quad-SPI serial flash read master (SPI mode 0, W25Q64CV-class).
//   It fetches a burst of DATA_SIZE-bit words from flash and streams them
//   to the host over a valid/ready interface. The flash pads use split
//   IO (o/oe/i) so the tristate buffers can sit at the top level.
//
//   Sequence: CMD (8 periods) -> ADDR (ADDR_W) -> DUMMY (DUMMY_CYC, skipped when 0)
//   -> DATA -> GAP (CS_IDLE cycles) -> IDLE.
//   SCLK = CLK/2. Each bit period is one CLK cycle with SCLK low, then one
//   cycle with SCLK high.
//
// Ports
//   CLK, ARESETn                  clock; asynchronous active-high reset
//   req_valid/req_ready           burst request handshake (req_ready = IDLE)
//   req_addr [ADDR_W]             flash start byte address
//   req_len  [LEN_W]              number of words minus one
//   rd_valid/rd_ready             read word handshake
//   rd_data  [DATA_SIZE]          assembled word; first flash byte is in the MSBs
//   rd_last                       marks the final word of the burst
//   busy                          high when the FSM is not idle
//   spi_sclk, spi_cs_n            serial clock (idles low), chip select
//   spi_io_o/oe/i [4]             IO3..IO0 output value, output enable, pad input
module qspi_flash_burst_reader #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_W    = 24,
    parameter int DUMMY_CYC = 8,
    parameter int QUAD      = 1,
    parameter int LEN_W     = 4,
    parameter int CS_IDLE   = 2
) (
    input  logic                 CLK,
    input  logic                 ARESETn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [LEN_W-1:0]     req_len,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_last,
    output logic                 busy,
    output logic                 spi_sclk,
    output logic                 spi_cs_n,
    output logic [3:0]           spi_io_o,
    output logic [3:0]           spi_io_oe,
    input  logic [3:0]           spi_io_i
);

    localparam int BPP   = (QUAD != 0) ? 4 : 1;            // data bits per SCLK period
    localparam int PPW   = DATA_SIZE / BPP;                // periods per word
    localparam int BMAX  = (ADDR_W > DATA_SIZE) ? ADDR_W : DATA_SIZE;
    localparam int BCW   = $clog2(BMAX + 1);
    localparam int GW    = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
    localparam int SRW   = 8 + ADDR_W;
    localparam logic [7:0] C_CMD = (QUAD != 0) ? 8'h6B : 8'h0B;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP
    } state_t;

    state_t                 r_state;
    logic                   r_sclk;
    logic                   r_cs_n;
    logic                   r_io0;
    logic                   r_oe0;
    // Command/address shifter. Bit 7 of the command goes straight to r_io0
    // when the request is accepted, so the shifter holds only the remaining bits.
    logic [SRW-2:0]         r_sr;
    logic [DATA_SIZE-BPP-1:0] r_rx;
    logic [BCW-1:0]         r_bcnt;     // periods remaining in this phase or word, minus one
    logic [LEN_W-1:0]       r_wcnt;
    logic [LEN_W-1:0]       r_len;
    logic                   r_fin;      // last word captured; wait for handover
    logic [GW-1:0]          r_gcnt;
    logic                   r_rd_valid;
    logic                   r_rd_last;
    logic [DATA_SIZE-1:0]   r_rd_data;

    logic [BPP-1:0]         w_in;
    logic [DATA_SIZE-1:0]   w_rx_next;
    logic                   w_last_word;
    logic                   w_stall;

    if (QUAD != 0) begin : g_quad
        assign w_in = spi_io_i[BPP-1:0];
    end else begin : g_single
        assign w_in = spi_io_i[1];
    end

    assign w_rx_next   = {r_rx, w_in};
    assign w_last_word = (r_wcnt == r_len);
    // Hold SCLK low rather than overwrite a word the consumer has not taken.
    assign w_stall     = (r_bcnt == '0) && r_rd_valid && !rd_ready;

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign spi_sclk  = r_sclk;
    assign spi_cs_n  = r_cs_n;
    // Only IO0 is ever driven. IO1..IO3 are inputs or held by board pull-ups.
    assign spi_io_o  = {3'b000, r_io0};
    assign spi_io_oe = {3'b000, r_oe0};
    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    assign rd_data   = r_rd_data;

    always_ff @(posedge CLK or posedge ARESETn) begin
        if (ARESETn) begin
            r_state    <= S_IDLE;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_io0      <= 1'b0;
            r_oe0      <= 1'b0;
            r_sr       <= '0;
            r_rx       <= '0;
            r_bcnt     <= '0;
            r_wcnt     <= '0;
            r_len      <= '0;
            r_fin      <= 1'b0;
            r_gcnt     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            // Handover. A word completing on this same edge overrides the clear below.
            if (r_rd_valid && rd_ready) begin
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_state <= S_CMD;
                        r_cs_n  <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_sr    <= {C_CMD[6:0], req_addr};
                        r_io0   <= C_CMD[7];
                        r_oe0   <= 1'b1;
                        r_bcnt  <= BCW'(7);
                        r_len   <= req_len;
                        r_wcnt  <= '0;
                        r_fin   <= 1'b0;
                    end
                end

                S_CMD, S_ADDR: begin
                    if (!r_sclk) begin
                        r_sclk <= 1'b1;
                    end else begin
                        // Falling edge: the period ends and IO0 moves to the next bit.
                        r_sclk <= 1'b0;
                        if (r_state == S_ADDR && r_bcnt == '0) begin
                            r_io0 <= 1'b0;
                            r_oe0 <= 1'b0;
                            if (DUMMY_CYC > 0) begin
                                r_state <= S_DUMMY;
                                r_bcnt  <= BCW'(DUMMY_CYC - 1);
                            end else begin
                                r_state <= S_DATA;
                                r_bcnt  <= BCW'(PPW - 1);
                            end
                        end else begin
                            r_io0 <= r_sr[SRW-2];
                            r_sr  <= {r_sr[SRW-3:0], 1'b0};
                            if (r_bcnt == '0) begin
                                r_state <= S_ADDR;
                                r_bcnt  <= BCW'(ADDR_W - 1);
                            end else begin
                                r_bcnt <= r_bcnt - 1'b1;
                            end
                        end
                    end
                end

                S_DUMMY: begin
                    if (!r_sclk) begin
                        r_sclk <= 1'b1;
                    end else begin
                        r_sclk <= 1'b0;
                        if (r_bcnt == '0) begin
                            r_state <= S_DATA;
                            r_bcnt  <= BCW'(PPW - 1);
                        end else begin
                            r_bcnt <= r_bcnt - 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (r_fin) begin
                        r_sclk <= 1'b0;
                        if (r_rd_valid && rd_ready) begin
                            r_state <= S_GAP;
                            r_cs_n  <= 1'b1;
                            r_gcnt  <= GW'(CS_IDLE - 1);
                        end
                    end else if (!r_sclk) begin
                        // Rising edge: sample the pads. The flash changed them on the last fall.
                        if (!w_stall) begin
                            r_sclk <= 1'b1;
                            r_rx   <= w_rx_next[DATA_SIZE-BPP-1:0];
                            if (r_bcnt == '0) begin
                                r_rd_data  <= w_rx_next;
                                r_rd_valid <= 1'b1;
                                r_rd_last  <= w_last_word;
                                if (w_last_word)
                                    r_fin <= 1'b1;
                                else
                                    r_wcnt <= r_wcnt + 1'b1;
                            end
                        end
                    end else begin
                        r_sclk <= 1'b0;
                        r_bcnt <= (r_bcnt == '0) ? BCW'(PPW - 1) : r_bcnt - 1'b1;
                    end
                end

                S_GAP: begin
                    if (r_gcnt == '0)
                        r_state <= S_IDLE;
                    else
                        r_gcnt <= r_gcnt - 1'b1;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_flash_burst_reader.sv
// Bench for qspi_flash_burst_reader. Two instances are checked:
//   u_a: default configuration (quad mode, 24-bit address, 8 dummy periods, 32-bit words)
//   u_b: single mode, 32-bit address, no dummy periods, 16-bit words
// Each instance has a behavioural flash model and a scoreboard queue.
module tb_qspi_flash_burst_reader;

    logic CLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- instance A (defaults) ----------------
    logic        a_req_valid = 1'b0;
    logic        a_req_ready;
    logic [23:0] a_req_addr = '0;
    logic [3:0]  a_req_len = '0;
    logic        a_rd_valid;
    logic        a_rd_ready = 1'b1;
    logic [31:0] a_rd_data;
    logic        a_rd_last, a_busy, a_sclk, a_cs_n;
    logic [3:0]  a_io_o, a_io_oe;
    logic [3:0]  a_io_i = 4'h0;

    qspi_flash_burst_reader u_a (
        .CLK(CLK), .ARESETn(ARESETn),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_addr(a_req_addr), .req_len(a_req_len),
        .rd_valid(a_rd_valid), .rd_ready(a_rd_ready),
        .rd_data(a_rd_data), .rd_last(a_rd_last), .busy(a_busy),
        .spi_sclk(a_sclk), .spi_cs_n(a_cs_n),
        .spi_io_o(a_io_o), .spi_io_oe(a_io_oe), .spi_io_i(a_io_i)
    );

    // ---------------- instance B (single, 16-bit, 32-bit addr, no dummy) ----------------
    logic        b_req_valid = 1'b0;
    logic        b_req_ready;
    logic [31:0] b_req_addr = '0;
    logic [3:0]  b_req_len = '0;
    logic        b_rd_valid;
    logic        b_rd_ready = 1'b1;
    logic [15:0] b_rd_data;
    logic        b_rd_last, b_busy, b_sclk, b_cs_n;
    logic [3:0]  b_io_o, b_io_oe;
    logic [3:0]  b_io_i = 4'h0;

    qspi_flash_burst_reader #(
        .DATA_SIZE(16), .ADDR_W(32), .DUMMY_CYC(0), .QUAD(0), .LEN_W(4), .CS_IDLE(2)
    ) u_b (
        .CLK(CLK), .ARESETn(ARESETn),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .req_len(b_req_len),
        .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
        .rd_data(b_rd_data), .rd_last(b_rd_last), .busy(b_busy),
        .spi_sclk(b_sclk), .spi_cs_n(b_cs_n),
        .spi_io_o(b_io_o), .spi_io_oe(b_io_oe), .spi_io_i(b_io_i)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- flash model A: 6Bh, 24-bit addr, 8 dummy, quad out ----------------
    int          fa_cnt = 0;
    int          fa_k;
    logic [7:0]  fa_cmd = '0;
    logic [23:0] fa_addr = '0;
    logic [31:0] fa_w;
    logic [31:0] fa_words [4];
    logic        fa_sclk_q = 1'b0, fa_cs_q = 1'b1;

    always @(a_sclk or a_cs_n) begin
        if (!a_cs_n && fa_cs_q) begin
            fa_cnt = 0; fa_cmd = '0; fa_addr = '0;
        end else if (!a_cs_n && a_sclk && !fa_sclk_q) begin
            fa_cnt++;
            if (fa_cnt <= 8)       fa_cmd  = {fa_cmd[6:0], a_io_o[0]};
            else if (fa_cnt <= 32) fa_addr = {fa_addr[22:0], a_io_o[0]};
        end else if (!a_cs_n && !a_sclk && fa_sclk_q && fa_cnt >= 40) begin
            fa_k   = fa_cnt - 40;
            fa_w   = fa_words[(fa_k / 8) % 4] >> (28 - 4 * (fa_k % 8));
            a_io_i = fa_w[3:0];
        end
        fa_sclk_q = a_sclk;
        fa_cs_q   = a_cs_n;
    end

    // ---------------- flash model B: 0Bh, 32-bit addr, no dummy, data on IO1 ----------------
    int          fb_cnt = 0;
    int          fb_k;
    logic [7:0]  fb_cmd = '0;
    logic [31:0] fb_addr = '0;
    logic [15:0] fb_w;
    logic [15:0] fb_words [4];
    logic        fb_sclk_q = 1'b0, fb_cs_q = 1'b1;

    always @(b_sclk or b_cs_n) begin
        if (!b_cs_n && fb_cs_q) begin
            fb_cnt = 0; fb_cmd = '0; fb_addr = '0;
        end else if (!b_cs_n && b_sclk && !fb_sclk_q) begin
            fb_cnt++;
            if (fb_cnt <= 8)       fb_cmd  = {fb_cmd[6:0], b_io_o[0]};
            else if (fb_cnt <= 40) fb_addr = {fb_addr[30:0], b_io_o[0]};
        end else if (!b_cs_n && !b_sclk && fb_sclk_q && fb_cnt >= 40) begin
            fb_k   = fb_cnt - 40;
            fb_w   = fb_words[(fb_k / 16) % 4] >> (15 - (fb_k % 16));
            b_io_i = {2'b00, fb_w[0], 1'b0};
        end
        fb_sclk_q = b_sclk;
        fb_cs_q   = b_cs_n;
    end

    // ---------------- scoreboards and per-cycle rules ----------------
    logic [32:0] qa [$];
    logic [16:0] qb [$];

    always @(negedge CLK) begin
        if (!ARESETn) begin
            check("a_oe_rule", 64'(a_io_oe == 4'h0 || (a_io_oe == 4'h1 && !a_cs_n && fa_cnt <= 32)), 64'(1));
            check("b_oe_rule", 64'(b_io_oe == 4'h0 || (b_io_oe == 4'h1 && !b_cs_n && fb_cnt <= 40)), 64'(1));
            check("a_ready_idle", 64'(a_req_ready), 64'(!a_busy));
            if (a_rd_valid && a_rd_ready) begin
                check("a_sb_nonempty", 64'(qa.size() != 0), 64'(1));
                if (qa.size() != 0) check("a_word", 64'({a_rd_last, a_rd_data}), 64'(qa.pop_front()));
            end
            if (b_rd_valid && b_rd_ready) begin
                check("b_sb_nonempty", 64'(qb.size() != 0), 64'(1));
                if (qb.size() != 0) check("b_word", 64'({b_rd_last, b_rd_data}), 64'(qb.pop_front()));
            end
        end
    end

    // Returns n such that rd_valid rose n-1 cycles after the caller's reference edge.
    task automatic wait_valid(input bit sel, input string tag, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(sel ? b_rd_valid : a_rd_valid) && n < 400);
        if (!(sel ? b_rd_valid : a_rd_valid)) begin
            check({tag, "_timeout"}, 64'(sel ? b_rd_valid : a_rd_valid), 64'(1));
            n = -1;
        end
    endtask

    task automatic wait_idle(input bit sel, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(sel ? b_req_ready : a_req_ready) && n < 400);
        check({tag, "_idle"}, 64'(sel ? b_req_ready : a_req_ready), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 ARESETn = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        // reset state
        check("rst_cs_n",   64'(a_cs_n),      64'(1));
        check("rst_sclk",   64'(a_sclk),      64'(0));
        check("rst_io_o",   64'(a_io_o),      64'(0));
        check("rst_io_oe",  64'(a_io_oe),     64'(0));
        check("rst_valid",  64'(a_rd_valid),  64'(0));
        check("rst_last",   64'(a_rd_last),   64'(0));
        check("rst_data",   64'(a_rd_data),   64'(0));
        check("rst_busy",   64'(a_busy),      64'(0));
        check("rst_b_cs_n", 64'(b_cs_n),      64'(1));
        ARESETn = 1'b0;
        @(posedge CLK); #1;

        // ---- single word, quad, defaults ----
        fa_words[0] = 32'hDEADBEEF;
        qa.push_back({1'b1, 32'hDEADBEEF});
        a_req_addr = 24'h000100; a_req_len = 4'd0; a_req_valid = 1'b1;
        @(posedge CLK); #1;
        a_req_valid = 1'b0;
        check("t1_cs_low",  64'(a_cs_n),  64'(0));
        check("t1_sclk",    64'(a_sclk),  64'(0));
        check("t1_io0_msb", 64'(a_io_o),  64'(0));
        check("t1_oe",      64'(a_io_oe), 64'(1));
        check("t1_busy",    64'(a_busy),  64'(1));
        wait_valid(0, "t1", n);
        check("t1_latency", 64'(n - 1), 64'(95));
        check("t1_last",    64'(a_rd_last), 64'(1));
        check("t1_data",    64'(a_rd_data), 64'(32'hDEADBEEF));
        @(negedge CLK);
        check("t1_gap0_cs",  64'(a_cs_n),      64'(1));
        check("t1_gap0_rdy", 64'(a_req_ready), 64'(0));
        @(negedge CLK);
        check("t1_gap1_cs",  64'(a_cs_n),      64'(1));
        check("t1_gap1_rdy", 64'(a_req_ready), 64'(0));
        @(negedge CLK);
        check("t1_idle_rdy", 64'(a_req_ready), 64'(1));
        check("t1_cmd",      64'(fa_cmd),      64'(8'h6B));
        check("t1_addr",     64'(fa_addr),     64'(24'h000100));
        @(posedge CLK); #1;

        // ---- 4-word burst, rd_ready tied high, request toggled while busy ----
        fa_words[0] = 32'h11111111; fa_words[1] = 32'h22222222;
        fa_words[2] = 32'h33333333; fa_words[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) qa.push_back({(i == 3), fa_words[i]});
        a_req_addr = 24'h000200; a_req_len = 4'd3; a_req_valid = 1'b1;
        @(posedge CLK); #1;
        a_req_valid = 1'b0;
        a_req_addr = 24'hFFFFFF; a_req_len = 4'd0;
        for (int i = 0; i < 20; i++) begin
            a_req_valid = ~a_req_valid;
            @(posedge CLK); #1;
            check("t2_ready_busy", 64'(a_req_ready), 64'(0));
        end
        a_req_valid = 1'b0;
        wait_valid(0, "t2_w0", n);
        check("t2_first_lat", 64'(n - 1 + 20), 64'(95));
        for (int i = 1; i < 4; i++) begin
            wait_valid(0, "t2_wn", n);
            check("t2_spacing", 64'(n), 64'(16));
        end
        wait_idle(0, "t2");
        check("t2_addr", 64'(fa_addr), 64'(24'h000200));
        repeat (5) @(negedge CLK);
        check("t2_no_extra", 64'(a_busy), 64'(0));
        @(posedge CLK); #1;

        // ---- 3-word burst with consumer stall ----
        fa_words[0] = 32'h5555AAAA; fa_words[1] = 32'h0F0F1234; fa_words[2] = 32'h89ABCDEF;
        for (int i = 0; i < 3; i++) qa.push_back({(i == 2), fa_words[i]});
        a_req_addr = 24'h000300; a_req_len = 4'd2; a_req_valid = 1'b1;
        @(posedge CLK); #1;
        a_req_valid = 1'b0;
        wait_valid(0, "t3_w0", n);
        @(posedge CLK); #1;
        a_rd_ready = 1'b0;
        repeat (35) @(posedge CLK);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("t3_stall_sclk", 64'(a_sclk), 64'(0));
            check("t3_stall_cs",   64'(a_cs_n), 64'(0));
        end
        check("t3_held_valid", 64'(a_rd_valid), 64'(1));
        check("t3_held_data",  64'(a_rd_data),  64'(32'h0F0F1234));
        check("t3_held_last",  64'(a_rd_last),  64'(0));
        @(posedge CLK); #1;
        a_rd_ready = 1'b1;
        wait_idle(0, "t3");
        check("t3_sb_drained", 64'(qa.size()), 64'(0));
        @(posedge CLK); #1;

        // ---- reset in the middle of the address phase ----
        a_req_addr = 24'h000400; a_req_len = 4'd0; a_req_valid = 1'b1;
        @(posedge CLK); #1;
        a_req_valid = 1'b0;
        repeat (30) @(posedge CLK);
        #1;
        ARESETn = 1'b1;
        #1;
        check("t4_cs_n",  64'(a_cs_n),  64'(1));
        check("t4_oe",    64'(a_io_oe), 64'(0));
        check("t4_sclk",  64'(a_sclk),  64'(0));
        check("t4_busy",  64'(a_busy),  64'(0));
        @(posedge CLK); #1;
        ARESETn = 1'b0;
        @(posedge CLK); #1;
        fa_words[0] = 32'hCAFEF00D;
        qa.push_back({1'b1, 32'hCAFEF00D});
        a_req_addr = 24'h0ABCDE; a_req_len = 4'd0; a_req_valid = 1'b1;
        @(posedge CLK); #1;
        a_req_valid = 1'b0;
        wait_valid(0, "t4", n);
        check("t4_latency", 64'(n - 1), 64'(95));
        wait_idle(0, "t4");
        check("t4_addr", 64'(fa_addr), 64'(24'h0ABCDE));

        // ---- single-bit mode, 16-bit word, 32-bit address, no dummy ----
        fb_words[0] = 16'hA5C3;
        qb.push_back({1'b1, 16'hA5C3});
        b_req_addr = 32'h12345678; b_req_len = 4'd0; b_req_valid = 1'b1;
        @(posedge CLK); #1;
        b_req_valid = 1'b0;
        check("t5_oe", 64'(b_io_oe), 64'(1));
        wait_valid(1, "t5", n);
        check("t5_latency", 64'(n - 1), 64'(111));
        check("t5_data",    64'(b_rd_data), 64'(16'hA5C3));
        wait_idle(1, "t5");
        check("t5_cmd",  64'(fb_cmd),  64'(8'h0B));
        check("t5_addr", 64'(fb_addr), 64'(32'h12345678));

        check("end_qa_empty", 64'(qa.size()), 64'(0));
        check("end_qb_empty", 64'(qb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
